// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl -- fetch-stage sequencer.
//
// Chooses the next-PC source, the PC load enable and the instruction-memory
// read strobe. It arbitrates between sequential fetch, EX-stage redirects
// (jump-register and jump/taken branch), decode stalls, halt and a memory
// timeout.
//
// Handshake: IMEM_ACK is the memory's valid for the request MEM_RD holds up.
// A fetch is accepted in the cycle where MEM_RD=1, IMEM_ACK=1 and STALL=0.
// In that cycle IF_VALID marks the word for IF/ID and PC_EN steps the PC.
// STALL acts as IF/ID's ready. When it is low the fetch is dropped, and the
// same address is requested again once STALL releases.
//
// Ports:
//   clock, reset  rising-edge clock, asynchronous active-high reset
//   JR_exe        EX jump-register redirect (PC source DOA_exe)
//   JUMP_exe      EX jump / taken-branch redirect (PC source jump_exe)
//   STALL         decode cannot accept into IF/ID
//   IMEM_ACK      instruction memory data valid this cycle
//   HALT          halt request; only reset leaves the halted state
//   SEL_DIR       PC mux select: 00 PC+4, 01 DOA_exe, 10 jump_exe, 11 zero
//   PC_EN         PC register load enable
//   MEM_RD        instruction-memory read strobe
//   FLUSH         invalidate IF/ID
//   IF_VALID      IF/ID captures a valid instruction this cycle
//   ERR_TIMEOUT   sticky memory-timeout flag
//   state_dbg     current FSM state, for observation only
// -----------------------------------------------------------------------------
module fetch_ctrl #(
  parameter int WAIT_W  = 4,
  parameter int TIMEOUT = 15
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       JR_exe,
  input  logic       JUMP_exe,
  input  logic       STALL,
  input  logic       IMEM_ACK,
  input  logic       HALT,
  output logic [1:0] SEL_DIR,
  output logic       PC_EN,
  output logic       MEM_RD,
  output logic       FLUSH,
  output logic       IF_VALID,
  output logic       ERR_TIMEOUT,
  output logic [2:0] state_dbg
);

  localparam logic [2:0] S_BOOT   = 3'd0;
  localparam logic [2:0] S_REQ    = 3'd1;
  localparam logic [2:0] S_HOLD   = 3'd2;
  localparam logic [2:0] S_HALTED = 3'd3;
  localparam logic [2:0] S_ERROR  = 3'd4;

  localparam logic [WAIT_W-1:0] TIMEOUT_C = WAIT_W'(TIMEOUT);

  logic [2:0]        state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              err_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_BOOT;
      wait_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      // Set on entry to ERROR. ERROR is only left through reset.
      err_q   <= err_q | (state_d == S_ERROR);
    end
  end

  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    SEL_DIR  = 2'b00;
    PC_EN    = 1'b0;
    MEM_RD   = 1'b0;
    FLUSH    = 1'b0;
    IF_VALID = 1'b0;

    unique case (state_q)
      S_BOOT: begin
        if (HALT) begin
          state_d = S_HALTED;
        end else begin
          // Load PC with zero and clear IF/ID on the first edge after reset.
          SEL_DIR = 2'b11;
          PC_EN   = 1'b1;
          FLUSH   = 1'b1;
          state_d = S_REQ;
        end
      end

      S_REQ, S_HOLD: begin
        if (HALT) begin
          state_d = S_HALTED;
        end else if (JR_exe || JUMP_exe) begin
          // A redirect discards the fetch in flight, whatever STALL or ACK say.
          SEL_DIR = JR_exe ? 2'b01 : 2'b10;
          PC_EN   = 1'b1;
          FLUSH   = 1'b1;
          wait_d  = '0;
          state_d = S_REQ;
        end else if (state_q == S_REQ) begin
          MEM_RD = 1'b1;
          if (!IMEM_ACK) begin
            // Count saturates at TIMEOUT and never wraps.
            if (wait_q != TIMEOUT_C) wait_d = wait_q + 1'b1;
            if (wait_d == TIMEOUT_C) state_d = S_ERROR;
          end else if (STALL) begin
            // The word arrived, but IF/ID is blocked. Keep the PC and refetch later.
            state_d = S_HOLD;
          end else begin
            PC_EN    = 1'b1;
            IF_VALID = 1'b1;
            wait_d   = '0;
          end
        end else begin
          if (!STALL) state_d = S_REQ;
        end
      end

      S_HALTED, S_ERROR: begin
        state_d = state_q;
      end

      default: begin
        state_d = S_BOOT;
      end
    endcase

    // While reset is held, show the boot outputs, even if HALT is high.
    if (reset) begin
      SEL_DIR  = 2'b11;
      PC_EN    = 1'b1;
      FLUSH    = 1'b1;
      MEM_RD   = 1'b0;
      IF_VALID = 1'b0;
    end
  end

  assign ERR_TIMEOUT = err_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_ctrl -- self-checking bench for fetch_ctrl.
// A small PC register driven by the DUT's SEL_DIR/PC_EN stands in for the
// fetch datapath, so fetch addresses can be checked as well as control outputs.
// -----------------------------------------------------------------------------
module tb_fetch_ctrl;

  localparam logic [31:0] PC_RST = 32'hDEAD_BEE0;
  localparam logic [6:0]  BOOT_OUTS = 7'b11_1_0_1_0_0;

  // Clock/reset
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic       JR_exe = 1'b0, JUMP_exe = 1'b0, STALL = 1'b0, IMEM_ACK = 1'b0, HALT = 1'b0;
  logic [1:0] SEL_DIR;
  logic       PC_EN, MEM_RD, FLUSH, IF_VALID, ERR_TIMEOUT;
  logic [2:0] state_dbg;

  fetch_ctrl #(.WAIT_W(4), .TIMEOUT(15)) dut (
    .clock(clock), .reset(reset), .JR_exe(JR_exe), .JUMP_exe(JUMP_exe),
    .STALL(STALL), .IMEM_ACK(IMEM_ACK), .HALT(HALT), .SEL_DIR(SEL_DIR),
    .PC_EN(PC_EN), .MEM_RD(MEM_RD), .FLUSH(FLUSH), .IF_VALID(IF_VALID),
    .ERR_TIMEOUT(ERR_TIMEOUT), .state_dbg(state_dbg)
  );

  // Fetch datapath stand-in.
  logic [31:0] doa_v = 32'h0000_1000;
  logic [31:0] jmp_v = 32'h0000_2000;
  logic [31:0] pc;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) pc <= PC_RST;
    else if (PC_EN) begin
      case (SEL_DIR)
        2'b00:   pc <= pc + 32'd4;
        2'b01:   pc <= doa_v;
        2'b10:   pc <= jmp_v;
        default: pc <= 32'd0;
      endcase
    end
  end

  // Scoreboard
  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] act_outs();
    return {SEL_DIR, PC_EN, MEM_RD, FLUSH, IF_VALID, ERR_TIMEOUT};
  endfunction

  // Reference model. Its modes are named after what the fetch stage is
  // doing, and expected outputs come straight from the priority rules.
  typedef enum int {M_BOOT, M_FETCH, M_WAIT_STALL, M_HALTED, M_DEAD} mmode_t;
  mmode_t      m_mode = M_BOOT;
  int          m_miss = 0;
  logic [31:0] m_pc   = PC_RST;

  // in = {halt, jr, jump, stall, ack}
  function automatic logic [6:0] model_out(input logic [4:0] in);
    logic h, jr, jp, st, ak;
    logic [1:0] sel;
    logic pe, mr, fl, iv, er;
    {h, jr, jp, st, ak} = in;
    sel = 2'b00; pe = 0; mr = 0; fl = 0; iv = 0; er = 0;
    if (reset) begin
      sel = 2'b11; pe = 1; fl = 1;
    end else begin
      case (m_mode)
        M_BOOT:   if (!h) begin sel = 2'b11; pe = 1; fl = 1; end
        M_DEAD:   er = 1;
        M_HALTED: ;
        default: begin
          if (h) ;
          else if (jr || jp) begin sel = jr ? 2'b01 : 2'b10; pe = 1; fl = 1; end
          else if (m_mode == M_FETCH) begin
            mr = 1;
            if (ak && !st) begin pe = 1; iv = 1; end
          end
        end
      endcase
    end
    return {sel, pe, mr, fl, iv, er};
  endfunction

  task automatic model_step(input logic [4:0] in);
    logic h, jr, jp, st, ak;
    {h, jr, jp, st, ak} = in;
    case (m_mode)
      M_BOOT: begin
        if (h) m_mode = M_HALTED;
        else begin m_mode = M_FETCH; m_pc = 32'd0; end
      end
      M_HALTED, M_DEAD: ;
      default: begin
        if (h) m_mode = M_HALTED;
        else if (jr) begin m_pc = doa_v; m_miss = 0; m_mode = M_FETCH; end
        else if (jp) begin m_pc = jmp_v; m_miss = 0; m_mode = M_FETCH; end
        else if (m_mode == M_FETCH) begin
          if (!ak) begin
            m_miss = (m_miss + 1 > 15) ? 15 : m_miss + 1;
            if (m_miss == 15) m_mode = M_DEAD;
          end else if (st) m_mode = M_WAIT_STALL;
          else begin m_pc = m_pc + 32'd4; m_miss = 0; end
        end else if (!st) m_mode = M_FETCH;
      end
    endcase
  endtask

  // Driver tasks. Every task starts and ends on a falling edge.
  logic [4:0] cur_in;

  task automatic drive_check(input logic [4:0] in, input string name);
    cur_in = in;
    {HALT, JR_exe, JUMP_exe, STALL, IMEM_ACK} = in;
    #1;
    check({name, " outs"}, 32'(act_outs()), 32'(model_out(in)));
    check({name, " pc"}, pc, m_pc);
  endtask

  task automatic tick();
    @(posedge clock);
    model_step(cur_in);
    @(negedge clock);
  endtask

  // Reset is raised between clock edges, and the outputs must react at once.
  task automatic do_reset(input string name);
    #2;
    reset = 1'b1;
    {HALT, JR_exe, JUMP_exe, STALL, IMEM_ACK} = 5'b00001;
    #1;
    check({name, " async rst outs"}, 32'(act_outs()), 32'(BOOT_OUTS));
    m_mode = M_BOOT; m_miss = 0; m_pc = PC_RST;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  typedef struct {
    logic [4:0] in;
    logic [6:0] exp;
  } vec_t;
  vec_t vecs[12];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] p0;
    logic [4:0]  rin;
    int drought;

    // Vector table: a sequence starting right after reset.
    vecs[0]  = '{5'b00001, 7'b11_1_0_1_0_0}; // boot
    vecs[1]  = '{5'b00001, 7'b00_1_1_0_1_0}; // accepted fetch
    vecs[2]  = '{5'b00000, 7'b00_0_1_0_0_0}; // miss
    vecs[3]  = '{5'b00011, 7'b00_0_1_0_0_0}; // ack while stalled -> hold
    vecs[4]  = '{5'b00011, 7'b00_0_0_0_0_0}; // hold
    vecs[5]  = '{5'b00100, 7'b10_1_0_1_0_0}; // jump from hold
    vecs[6]  = '{5'b01101, 7'b01_1_0_1_0_0}; // jr wins over jump and ack
    vecs[7]  = '{5'b00010, 7'b00_0_1_0_0_0}; // stall without ack counts as a miss
    vecs[8]  = '{5'b00001, 7'b00_1_1_0_1_0}; // accepted fetch
    vecs[9]  = '{5'b10101, 7'b00_0_0_0_0_0}; // halt beats jump
    vecs[10] = '{5'b00001, 7'b00_0_0_0_0_0}; // halted
    vecs[11] = '{5'b01000, 7'b00_0_0_0_0_0}; // halted ignores redirect

    @(negedge clock);
    check("reset outs", 32'(act_outs()), 32'(BOOT_OUTS));
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      cur_in = vecs[i].in;
      {HALT, JR_exe, JUMP_exe, STALL, IMEM_ACK} = vecs[i].in;
      #1;
      check($sformatf("vec%0d", i), 32'(act_outs()), 32'(vecs[i].exp));
      tick();
    end

    // Sequential fetch from zero.
    do_reset("seq");
    drive_check(5'b00001, "seq boot");
    tick();
    for (int k = 0; k < 4; k++) begin
      drive_check(5'b00001, "seq fetch");
      check("seq if_valid", 32'(IF_VALID), 32'd1);
      check("seq addr", pc, 32'(k * 4));
      tick();
    end

    // Three-cycle memory wait.
    for (int k = 0; k < 3; k++) begin
      drive_check(5'b00000, "wait");
      check("wait strobe", 32'({MEM_RD, PC_EN}), 32'b10);
      tick();
    end
    drive_check(5'b00001, "wait done");
    check("wait done", 32'({PC_EN, IF_VALID, ERR_TIMEOUT}), 32'b110);
    tick();

    // Redirects.
    drive_check(5'b00101, "jump");
    check("jump outs", 32'(act_outs()), 32'(7'b10_1_0_1_0_0));
    tick();
    drive_check(5'b00001, "jump tgt");
    check("jump addr", pc, jmp_v);
    tick();
    drive_check(5'b01101, "jr+jump");
    check("jr sel", 32'(SEL_DIR), 32'b01);
    tick();
    drive_check(5'b00001, "jr tgt");
    check("jr addr", pc, doa_v);
    tick();

    // Stall, hold and refetch of the same address.
    drive_check(5'b00011, "stall req");
    p0 = pc;
    tick();
    drive_check(5'b00011, "hold1");
    check("hold1 en", 32'({PC_EN, MEM_RD}), 32'b00);
    tick();
    drive_check(5'b00010, "hold2");
    tick();
    drive_check(5'b00001, "hold release");
    tick();
    drive_check(5'b00001, "refetch");
    check("refetch", 32'({MEM_RD, IF_VALID}), 32'b11);
    check("refetch addr", pc, p0);
    tick();
    drive_check(5'b00011, "stall2");
    tick();
    drive_check(5'b00110, "hold jump");
    check("hold jump", 32'({SEL_DIR, FLUSH}), 32'b101);
    tick();

    // Timeout: 14 misses must not trip, 15 in a row must.
    do_reset("tmo");
    drive_check(5'b00001, "tmo boot");
    tick();
    for (int k = 0; k < 14; k++) begin drive_check(5'b00000, "tmo miss14"); tick(); end
    drive_check(5'b00001, "tmo ack");
    check("tmo no err", 32'(ERR_TIMEOUT), 32'd0);
    tick();
    for (int k = 0; k < 15; k++) begin drive_check(5'b00000, "tmo miss15"); tick(); end
    drive_check(5'b00001, "tmo err");
    check("tmo err", 32'({ERR_TIMEOUT, MEM_RD, PC_EN}), 32'b100);
    tick();
    drive_check(5'b10001, "tmo err halt");
    check("tmo sticky", 32'(ERR_TIMEOUT), 32'd1);
    tick();
    do_reset("tmo clr");
    check("tmo cleared", 32'(ERR_TIMEOUT), 32'd0);

    // HALT together with JUMP.
    drive_check(5'b00001, "halt boot");
    tick();
    drive_check(5'b00001, "halt pre");
    tick();
    drive_check(5'b10101, "halt+jump");
    check("halt pc_en", 32'(PC_EN), 32'd0);
    tick();
    drive_check(5'b00001, "halted");
    check("halted outs", 32'(act_outs()), 32'd0);
    tick();

    // Random stimulus against the model, with mid-cycle resets.
    do_reset("rnd");
    drought = 0;
    for (int i = 0; i < 1500; i++) begin
      if (((m_mode == M_HALTED || m_mode == M_DEAD) && $urandom_range(0, 7) == 0) ||
          $urandom_range(0, 249) == 0)
        do_reset("rnd");
      if (drought == 0 && $urandom_range(0, 59) == 0) drought = $urandom_range(10, 18);
      doa_v = 32'($urandom_range(0, 1023)) << 2;
      jmp_v = 32'($urandom_range(0, 1023)) << 2;
      rin[4] = ($urandom_range(0, 149) == 0);
      rin[3] = ($urandom_range(0, 15) == 0);
      rin[2] = ($urandom_range(0, 11) == 0);
      rin[1] = ($urandom_range(0, 3) == 0);
      rin[0] = (drought > 0) ? 1'b0 : ($urandom_range(0, 4) != 0);
      if (drought > 0) begin
        drought--;
        rin[3] = 1'b0;
        rin[2] = 1'b0;
        rin[4] = 1'b0;
      end
      drive_check(rin, "rnd");
      if (IF_VALID && FLUSH) check("rnd ifv_flush", 32'd1, 32'd0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
